// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges the core's 32-bit byte-addressed request bus to a
// single-port synchronous word RAM, with programmable wait states and a
// one-entry read buffer.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cpu_addr/cpu_wdata  - byte address and store data from the core
//   cpu_read/cpu_write  - load strobe (advisory, reads are implicit) and store strobe
//   cpu_rdata/cpu_ready - read data and access-complete to the core
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata - synchronous RAM port
//   bus_err             - sticky out-of-range flag
//   stat_reads/stat_writes/stat_stalls - activity counters
//
// Optional feature: define MEM_BUS_CTRL_STATS_EN to build the saturating
// activity counters; otherwise the stat ports are tied to zero.
module mem_bus_ctrl #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              bus_err,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stalls
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WR_ACK} state_t;

  // Cycle index (from 0) of the final READ / WRITE cycle.
  localparam logic [4:0] RD_LAST = 5'(WAIT_CYCLES + 1);
  localparam logic [4:0] WR_LAST = 5'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        oor_q, oor_d;
  logic [31:0] rd_tag_q, rd_tag_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic        rd_valid_q, rd_valid_d;
  logic        bus_err_q, bus_err_d;

  logic        req_oor_s;
  logic        hit_s;
  logic        idle_hit_s;
  logic        unused_bits_s;

  assign req_oor_s     = |cpu_addr[31:ADDR_W+2];
  assign hit_s         = rd_valid_q && (cpu_addr[31:2] == rd_tag_q[31:2]);
  assign idle_hit_s    = (state_q == IDLE) && !cpu_write && hit_s;
  assign unused_bits_s = ^{cpu_read, rd_tag_q[1:0]};

  // Next-state and buffer update logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    rd_tag_d   = rd_tag_q;
    rd_buf_d   = rd_buf_q;
    rd_valid_d = rd_valid_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          state_d = WRITE;
          cnt_d   = 5'd0;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          oor_d   = req_oor_s;
        end else if (!hit_s) begin
          // Every non-write idle cycle is an implicit read.
          state_d = READ;
          cnt_d   = 5'd0;
          addr_d  = cpu_addr;
          oor_d   = req_oor_s;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (cnt_q == RD_LAST) begin
          state_d    = IDLE;
          rd_buf_d   = oor_q ? ERR_DATA : ram_rdata;
          rd_tag_d   = addr_q;
          rd_valid_d = 1'b1;
          bus_err_d  = bus_err_q | oor_q;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d   = WR_ACK;
          bus_err_d = bus_err_q | oor_q;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      WR_ACK: begin
        state_d = IDLE;
        // Keep the read buffer coherent with a store to the buffered word.
        if (addr_q[31:2] == rd_tag_q[31:2]) begin
          rd_buf_d = wdata_q;
        end else begin
          rd_buf_d = rd_buf_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      oor_q      <= 1'b0;
      rd_tag_q   <= 32'd0;
      rd_buf_q   <= 32'd0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      rd_tag_q   <= rd_tag_d;
      rd_buf_q   <= rd_buf_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Core and RAM side outputs; RAM strobes only on the first access cycle.
  always_comb begin
    cpu_ready = idle_hit_s || (state_q == WR_ACK);
    cpu_rdata = idle_hit_s ? rd_buf_q : 32'd0;
    ram_en    = ((state_q == READ) || (state_q == WRITE)) && (cnt_q == 5'd0) && !oor_q;
    ram_we    = (state_q == WRITE) && (cnt_q == 5'd0) && !oor_q;
    ram_addr  = addr_q[ADDR_W+1:2];
    ram_wdata = wdata_q;
    bus_err   = bus_err_q;
  end

`ifdef MEM_BUS_CTRL_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;
  logic        stall_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  // Counter next values; WR_ACK always has ready high so it never stalls.
  always_comb begin
    stall_s       = (state_q != WR_ACK) && !cpu_ready;
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    stat_stalls_d = stat_stalls_q;
    if ((state_q == IDLE) && (state_d == READ)) begin
      stat_reads_d = sat_inc(stat_reads_q);
    end else begin
      stat_reads_d = stat_reads_q;
    end
    if ((state_q == IDLE) && (state_d == WRITE)) begin
      stat_writes_d = sat_inc(stat_writes_q);
    end else begin
      stat_writes_d = stat_writes_q;
    end
    if (stall_s) begin
      stat_stalls_d = sat_inc(stat_stalls_q);
    end else begin
      stat_stalls_d = stat_stalls_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q  <= 32'd0;
      stat_writes_q <= 32'd0;
      stat_stalls_q <= 32'd0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_stalls = stat_stalls_q;
`else
  assign stat_reads  = 32'd0;
  assign stat_writes = 32'd0;
  assign stat_stalls = 32'd0;
`endif

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory controller directly downstream of the CPU core's memory interface; converts its 32-bit byte-addressed request bus into a single-port synchronous word RAM.
- Produces `mem_ready` with configurable wait states and keeps a one-entry read buffer, so the core's stalled re-sampling of the same address completes without re-accessing RAM.
- Top level resolves the core's inout data bus into `cpu_wdata` / `cpu_rdata`.

Parameters:
- `ADDR_W`, 12: RAM word-address width; 2^ADDR_W words.
- `WAIT_CYCLES`, 0: extra RAM access cycles per read or write, range 0..15.
- `ERR_DATA`, 32'hDEADBEEF: read data returned for out-of-range addresses.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous reset, active-high.
- `cpu_addr` input 32: byte address from the core.
- `cpu_wdata` input 32: store data.
- `cpu_read` input 1: load strobe; advisory, see Behaviour.
- `cpu_write` input 1: store strobe.
- `cpu_rdata` output 32: read data, valid while `cpu_ready`=1 on a read.
- `cpu_ready` output 1: access complete; drives the core's `mem_ready`.
- `ram_en` output 1: RAM enable.
- `ram_we` output 1: RAM write enable.
- `ram_addr` output ADDR_W: RAM word address.
- `ram_wdata` output 32: RAM write data.
- `ram_rdata` input 32: RAM read data, valid one cycle after `ram_en` with `ram_we`=0.
- `bus_err` output 1: sticky out-of-range flag.
- `stat_reads` output 32: read-miss counter.
- `stat_writes` output 32: write counter.
- `stat_stalls` output 32: stall-cycle counter.

Behaviour:
- **Reset:** `rst`=1 at a clock edge has these effects.
  - State=IDLE.
  - All outputs 0 except `cpu_rdata`=0.
  - `rd_valid`=0, `bus_err`=0, counters=0.
  - Reset mid-access aborts it; no RAM write completes after the reset edge.
- **Request classification:** in IDLE, `cpu_write`=1 is a write; otherwise the cycle is a read of `cpu_addr`. The core fetches without asserting `cpu_read`, so reads are implicit.
- **Address handling:**
  - Word index = `cpu_addr[ADDR_W+1:2]`; bits [1:0] are ignored.
  - The address is out of range if any `cpu_addr[31:ADDR_W+2]` bit is nonzero.
- **Read buffer:** `rd_tag` (32), `rd_buf` (32), `rd_valid`.
  - Hit = `rd_valid` && `cpu_addr[31:2]`==`rd_tag[31:2]`.
- **States:** IDLE, READ, WRITE, WR_ACK.
- **IDLE:**
  - Write: latch address and data, go to WRITE, `cpu_ready`=0.
  - Read hit: `cpu_ready`=1 combinationally, `cpu_rdata`=`rd_buf`; stay in IDLE.
  - Read miss: latch address, go to READ, `cpu_ready`=0.
- **READ:**
  - Lasts 2+`WAIT_CYCLES` cycles.
  - `ram_en`=1 only on the first cycle, with `ram_addr` = latched word index.
  - On the last cycle, capture `ram_rdata` into `rd_buf`, set `rd_tag`, set `rd_valid`=1, and go to IDLE.
  - The next cycle hits. Read latency is 3+`WAIT_CYCLES` cycles from first presentation to `cpu_ready`.
  - Out-of-range read: no `ram_en`, capture `ERR_DATA`, set `bus_err`=1.
- **WRITE:**
  - Lasts 1+`WAIT_CYCLES` cycles.
  - `ram_en`=`ram_we`=1 only on the first cycle, with latched address and data.
  - Then go to WR_ACK.
  - Out-of-range write: no RAM strobes, set `bus_err`=1.
- **WR_ACK:**
  - One cycle with `cpu_ready`=1; go to IDLE.
  - Write latency is 2+`WAIT_CYCLES` cycles.
  - If the written word equals `rd_tag`, then `rd_buf` ← written data (write-through coherence), on the same edge.
- **Write still held:** if `cpu_write` is still 1 in the IDLE cycle after WR_ACK, a new write starts. The requester drops the strobe on ready.
- **Inputs during READ/WRITE:** `cpu_addr` and `cpu_write` are ignored; latched values are used.
- **Read data encoding:** `cpu_rdata` = `rd_buf` whenever `cpu_ready`=1 on a read, else 0.

Optional Feature:
- `MEM_BUS_CTRL_STATS_EN` defined: 32-bit saturating counters (saturate at 32'hFFFFFFFF), cleared by `rst`.
  - `stat_reads` increments on each IDLE→READ.
  - `stat_writes` increments on each IDLE→WRITE.
  - `stat_stalls` increments on every cycle with `cpu_ready`=0 while in READ or WRITE, or in IDLE on a miss or write.
- Not defined: counter logic is absent and the three stat ports are tied to 0.

Test Plan:
- **Reset mid-write:** `WAIT_CYCLES`=2; assert `rst` during the WRITE second cycle → no further `ram_we`, state IDLE, `cpu_ready`=0, `rd_valid`=0; a subsequent read of that address misses.
- **Read miss then hit:** `WAIT_CYCLES`=0; RAM[5]=32'h12345678; hold `cpu_addr`=32'h14 from c0 → `ram_en` at c1 with `ram_addr`=5, `cpu_ready`=1 and `cpu_rdata`=32'h12345678 at c3; re-presenting 32'h14 later → ready in the same cycle, no `ram_en`.
- **Write with wait states:** `WAIT_CYCLES`=2; write 32'hCAFEF00D to 32'h20 → one `ram_we` pulse at c1 with `ram_addr`=8, `cpu_ready`=1 only at c4; after `cpu_write` drops, read of 32'h20 returns 32'hCAFEF00D.
- **Write-through coherence:** read 32'h14 (buffered), then write 32'hAAAA5555 to 32'h16 → re-read of 32'h14 hits with no `ram_en` and returns 32'hAAAA5555.
- **Out of range:** `ADDR_W`=12; read 32'h00010000 → no `ram_en`, `cpu_rdata`=32'hDEADBEEF on ready, `bus_err`=1 and stays 1 until `rst`; write 32'h00010000 → no `ram_we`, ready after 2+`WAIT_CYCLES` cycles.
- **Stats:** with `MEM_BUS_CTRL_STATS_EN`, `WAIT_CYCLES`=0, run 2 read misses, 1 hit, 1 write → `stat_reads`=2, `stat_writes`=1, `stat_stalls`=8; without the macro → all three stat ports 0.
